// File: rtl/lc3b_fetch_unit.sv
// -----------------------------------------------------------------------------
// lc3b_fetch_unit
// LC-3b pipeline fetch stage. Owns the PC register and the FETCH->DECODE (DE)
// latch. The PC addresses instruction memory, the fetched word plus its PC+2
// are captured into DE, and the next PC is chosen between the sequential
// address, a taken branch target or a trap vector (both resolved in MEM).
//
// Ports
//   clk              in   1   pipeline clock, all state updates on posedge
//   rst              in   1   synchronous active-high reset
//   dep_stall        in   1   decode data-dependency stall
//   mem_stall        in   1   MEM stage waiting on data memory
//   v_de_br_stall    in   1   valid control instruction in DE
//   v_agex_br_stall  in   1   valid control instruction in AGEX
//   v_mem_br_stall   in   1   valid control instruction in MEM
//   imem_r           in   1   instruction memory ready
//   mem_pcmux        in   2   0/3 = PC+2, 1 = target_pc, 2 = trap_pc
//   target_pc        in   16  branch/JMP target from MEM
//   trap_pc          in   16  trap vector from MEM
//   instr            in   16  instruction word at address pc
//   pc               out  16  current PC (instruction-memory address)
//   new_pc           out  16  next-PC mux output (combinational)
//   ld_pc            out  1   PC load enable (combinational)
//   ld_de            out  1   DE latch load enable (combinational)
//   de_npc           out  16  PC+2 of the instruction held in DE
//   de_ir            out  16  instruction held in DE
//   de_v             out  1   valid bit of DE
//
// Optional build macro FETCH_PERF_CNT_EN adds:
//   perf_fetched     out  32  count of valid instructions loaded into DE
//   perf_stalled     out  32  count of cycles in which the PC did not load
// -----------------------------------------------------------------------------
module lc3b_fetch_unit #(
  parameter logic [15:0] RESET_PC = 16'h3000,
  parameter logic [15:0] PC_INC   = 16'd2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        dep_stall,
  input  logic        mem_stall,
  input  logic        v_de_br_stall,
  input  logic        v_agex_br_stall,
  input  logic        v_mem_br_stall,
  input  logic        imem_r,
  input  logic [1:0]  mem_pcmux,
  input  logic [15:0] target_pc,
  input  logic [15:0] trap_pc,
  input  logic [15:0] instr,
  output logic [15:0] pc,
  output logic [15:0] new_pc,
  output logic        ld_pc,
  output logic        ld_de,
  output logic [15:0] de_npc,
  output logic [15:0] de_ir,
  output logic        de_v
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_stalled
`endif
);

  logic [15:0] r_pc;
  logic [15:0] r_de_npc;
  logic [15:0] r_de_ir;
  logic        r_de_v;

  logic [15:0] w_pc_plus;
  logic [15:0] w_new_pc;
  logic        w_redirect;
  logic        w_br_any;
  logic        w_ld_pc;
  logic        w_ld_de;
  logic        w_de_v_in;

  // Sequential address wraps modulo 2^16 (FFFE -> 0000).
  assign w_pc_plus = r_pc + PC_INC;
  assign w_br_any  = v_de_br_stall | v_agex_br_stall | v_mem_br_stall;

  // Next-PC selection and redirect decode; encoding 3 falls back to PC+2.
  always_comb begin
    w_new_pc   = w_pc_plus;
    w_redirect = 1'b0;
    case (mem_pcmux)
      2'd1: begin
        w_new_pc   = target_pc;
        w_redirect = 1'b1;
      end
      2'd2: begin
        w_new_pc   = trap_pc;
        w_redirect = 1'b1;
      end
      default: begin
        w_new_pc   = w_pc_plus;
        w_redirect = 1'b0;
      end
    endcase
  end

  // Load enables: a MEM redirect overrides dependency/branch/imem stalls, but
  // a stalled MEM stage freezes everything, redirect included.
  always_comb begin
    w_ld_pc = 1'b0;
    if (mem_stall) begin
      w_ld_pc = 1'b0;
    end else if (w_redirect) begin
      w_ld_pc = 1'b1;
    end else begin
      w_ld_pc = imem_r & ~dep_stall & ~w_br_any;
    end
  end

  assign w_ld_de   = ~dep_stall & ~mem_stall;
  // A bubble enters DE whenever memory is not ready or a branch is in flight.
  assign w_de_v_in = imem_r & ~w_br_any;

  // PC register and DE latch; the two load enables act independently.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc     <= RESET_PC;
      r_de_npc <= 16'h0000;
      r_de_ir  <= 16'h0000;
      r_de_v   <= 1'b0;
    end else begin
      if (w_ld_pc) begin
        r_pc <= w_new_pc;
      end
      if (w_ld_de) begin
        r_de_npc <= w_pc_plus;
        r_de_ir  <= instr;
        r_de_v   <= w_de_v_in;
      end
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] r_perf_fetched;
  logic [31:0] r_perf_stalled;

  // Performance counters, free-running and wrapping at 2^32.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_perf_fetched <= 32'd0;
      r_perf_stalled <= 32'd0;
    end else begin
      if (w_ld_de & w_de_v_in) begin
        r_perf_fetched <= r_perf_fetched + 32'd1;
      end
      if (!w_ld_pc) begin
        r_perf_stalled <= r_perf_stalled + 32'd1;
      end
    end
  end

  assign perf_fetched = r_perf_fetched;
  assign perf_stalled = r_perf_stalled;
`endif

  assign pc     = r_pc;
  assign new_pc = w_new_pc;
  assign ld_pc  = w_ld_pc;
  assign ld_de  = w_ld_de;
  assign de_npc = r_de_npc;
  assign de_ir  = r_de_ir;
  assign de_v   = r_de_v;

endmodule

// File: tb/tb_lc3b_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_lc3b_fetch_unit
// Self-checking bench for lc3b_fetch_unit. Each cycle the bench drives the
// inputs, predicts the combinational outputs and the state after the next
// posedge from its own reference model, pushes the predicted state into a
// scoreboard queue and pops/compares it once the DUT has clocked.
// -----------------------------------------------------------------------------
module tb_lc3b_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        dep_stall;
  logic        mem_stall;
  logic        v_de_br_stall;
  logic        v_agex_br_stall;
  logic        v_mem_br_stall;
  logic        imem_r;
  logic [1:0]  mem_pcmux;
  logic [15:0] target_pc;
  logic [15:0] trap_pc;
  logic [15:0] instr;
  logic [15:0] pc;
  logic [15:0] new_pc;
  logic        ld_pc;
  logic        ld_de;
  logic [15:0] de_npc;
  logic [15:0] de_ir;
  logic        de_v;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetched;
  logic [31:0] perf_stalled;
`endif

  lc3b_fetch_unit dut (
    .clk             (clk),
    .rst             (rst),
    .dep_stall       (dep_stall),
    .mem_stall       (mem_stall),
    .v_de_br_stall   (v_de_br_stall),
    .v_agex_br_stall (v_agex_br_stall),
    .v_mem_br_stall  (v_mem_br_stall),
    .imem_r          (imem_r),
    .mem_pcmux       (mem_pcmux),
    .target_pc       (target_pc),
    .trap_pc         (trap_pc),
    .instr           (instr),
    .pc              (pc),
    .new_pc          (new_pc),
    .ld_pc           (ld_pc),
    .ld_de           (ld_de),
    .de_npc          (de_npc),
    .de_ir           (de_ir),
    .de_v            (de_v)
`ifdef FETCH_PERF_CNT_EN
    ,
    .perf_fetched    (perf_fetched),
    .perf_stalled    (perf_stalled)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] pc;
    logic [15:0] npc;
    logic [15:0] ir;
    logic        v;
    logic [31:0] fetched;
    logic [31:0] stalled;
  } exp_t;

  exp_t sb_q[$];
  exp_t m;          // model state after the last posedge
  int   total = 0;
  int   bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h at t=%0t", tag, got, exp, $time);
    end
  endtask

  // One clock cycle: drive, predict, push; then clock, pop, compare.
  task automatic cyc(input logic r, input logic dep, input logic mst,
                     input logic bde, input logic bag, input logic bme,
                     input logic imr, input logic [1:0] mux,
                     input logic [15:0] tgt, input logic [15:0] trp,
                     input logic [15:0] ins);
    logic [15:0] pcp, npc;
    logic        redir, brany, lpc, lde, vin;
    exp_t        e, got;
    rst = r; dep_stall = dep; mem_stall = mst;
    v_de_br_stall = bde; v_agex_br_stall = bag; v_mem_br_stall = bme;
    imem_r = imr; mem_pcmux = mux; target_pc = tgt; trap_pc = trp; instr = ins;
    #4;
    pcp   = m.pc + 16'd2;
    redir = (mux == 2'd1) || (mux == 2'd2);
    npc   = (mux == 2'd1) ? tgt : (mux == 2'd2) ? trp : pcp;
    brany = bde | bag | bme;
    lpc   = !mst && (redir || (imr && !dep && !brany));
    lde   = !dep && !mst;
    vin   = imr && !brany;
    if (!r) begin
      check("new_pc", 32'(new_pc), 32'(npc));
      check("ld_pc", 32'(ld_pc), 32'(lpc));
      check("ld_de", 32'(ld_de), 32'(lde));
    end
    e = m;
    if (r) begin
      e.pc = 16'h3000; e.npc = 16'h0000; e.ir = 16'h0000; e.v = 1'b0;
      e.fetched = 32'd0; e.stalled = 32'd0;
    end else begin
      if (lpc) e.pc = npc;
      if (lde) begin e.npc = pcp; e.ir = ins; e.v = vin; end
      if (lde && vin) e.fetched = m.fetched + 32'd1;
      if (!lpc) e.stalled = m.stalled + 32'd1;
    end
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    got = sb_q.pop_front();
    check("pc", 32'(pc), 32'(got.pc));
    check("de_npc", 32'(de_npc), 32'(got.npc));
    check("de_ir", 32'(de_ir), 32'(got.ir));
    check("de_v", 32'(de_v), 32'(got.v));
`ifdef FETCH_PERF_CNT_EN
    check("perf_fetched", perf_fetched, got.fetched);
    check("perf_stalled", perf_stalled, got.stalled);
`endif
    m = got;
  endtask

  // Shorthand for a cycle with no stalls except the ones given.
  task automatic run(input logic imr, input logic [1:0] mux, input logic [15:0] tgt);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, imr, mux, tgt, 16'h0000, 16'h1234);
  endtask

  initial begin
    m = '{16'h0000, 16'h0000, 16'h0000, 1'b0, 32'd0, 32'd0};
    @(posedge clk);
    #1;
    // Reset
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 16'h0000, 16'h0000, 16'h1234);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 16'h0000, 16'h0000, 16'h1234);
    check("rst_pc", 32'(pc), 32'h3000);
    check("rst_de_v", 32'(de_v), 32'd0);

    // Free run
    run(1'b1, 2'd0, 16'h0000);
    check("run_pc1", 32'(pc), 32'h3002);
    check("run_npc1", 32'(de_npc), 32'h3002);
    check("run_ir1", 32'(de_ir), 32'h1234);
    run(1'b1, 2'd0, 16'h0000);
    check("run_pc2", 32'(pc), 32'h3004);

    // Instruction memory not ready
    for (int i = 0; i < 3; i++) begin
      run(1'b0, 2'd0, 16'h0000);
      check("imem_hold_pc", 32'(pc), 32'h3004);
      check("imem_bubble", 32'(de_v), 32'd0);
    end
    run(1'b1, 2'd0, 16'h0000);
    check("imem_resume_npc", 32'(de_npc), 32'h3006);
    check("imem_resume_v", 32'(de_v), 32'd1);

    // Branch shadow then redirect to target
    for (int i = 0; i < 2; i++) begin
      cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 2'd0, 16'h4000, 16'h0000, 16'h1234);
      check("br_hold_pc", 32'(pc), 32'h3006);
      check("br_bubble", 32'(de_v), 32'd0);
    end
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 2'd1, 16'h4000, 16'h0000, 16'h1234);
    check("br_redirect_pc", 32'(pc), 32'h4000);

    // Dependency stall with trap redirect: pc loads, DE holds
    run(1'b1, 2'd0, 16'h0000);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd2, 16'h0000, 16'h0200, 16'hABCD);
    check("trap_pc", 32'(pc), 32'h0200);
    check("trap_de_hold", 32'(de_ir), 32'h1234);

    // Memory stall blocks redirect
    for (int i = 0; i < 2; i++) begin
      cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2'd1, 16'h5000, 16'h0000, 16'h5555);
      check("mst_hold_pc", 32'(pc), 32'h0200);
    end
    run(1'b1, 2'd1, 16'h5000);
    check("mst_release_pc", 32'(pc), 32'h5000);

    // Reserved mux encoding acts as sequential
    run(1'b1, 2'd3, 16'h7777);
    check("mux3_pc", 32'(pc), 32'h5002);

    // Wraparound at top of address space
    run(1'b1, 2'd1, 16'hFFFE);
    run(1'b1, 2'd0, 16'h0000);
    check("wrap_pc", 32'(pc), 32'h0000);
    check("wrap_npc", 32'(de_npc), 32'h0000);

    // Random mix
    for (int i = 0; i < 60; i++) begin
      cyc(1'b0, ($urandom_range(3) == 0), ($urandom_range(4) == 0),
          ($urandom_range(5) == 0), ($urandom_range(5) == 0), ($urandom_range(5) == 0),
          ($urandom_range(3) != 0), 2'($urandom_range(3)),
          16'($urandom), 16'($urandom), 16'($urandom));
    end

    // Reset in mid-run overrides everything
    cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2'd1, 16'h9999, 16'h0000, 16'h4321);
    check("midrst_pc", 32'(pc), 32'h3000);
    check("midrst_de_v", 32'(de_v), 32'd0);
    run(1'b1, 2'd0, 16'h0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
